// File: rtl/ctrl_pkg.sv
// Shared opcodes, FSM states and ALU mode codes for seq_control_unit.
// Defining CTRL_LOGIC_OPS_EN makes the AND/OR opcodes execute as three-step ALU ops.
package ctrl_pkg;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_AND = 2'b10;
    localparam logic [1:0] MODE_OR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_T3   = 2'd3
    } state_e;

    function automatic logic is_alu_op(input logic [2:0] op);
`ifdef CTRL_LOGIC_OPS_EN
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
`else
        return (op == OP_ADD) || (op == OP_SUB);
`endif
    endfunction

    function automatic logic [1:0] alu_mode_of(input logic [2:0] op);
        case (op)
            OP_SUB:  return MODE_SUB;
            OP_AND:  return MODE_AND;
            OP_OR:   return MODE_OR;
            default: return MODE_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_onehot_dec.sv
// Binary register address plus enable to one-hot register strobe vector.
module ctrl_onehot_dec #(
    parameter int ADDR_W = 4
) (
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic                   en_i,
    output logic [(1<<ADDR_W)-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) onehot_o[addr_i] = 1'b1;
    end

endmodule

// File: rtl/seq_control_unit.sv
// Multi-cycle control FSM for the register-file/ALU datapath: 1-3 steps per instruction.
// Build option CTRL_LOGIC_OPS_EN enables AND/OR opcodes; otherwise they pulse illegal.
module seq_control_unit
    import ctrl_pkg::*;
#(
    parameter  int REG_ADDR_W = 4,
    parameter  int CNT_W      = 16,
    localparam int INSTR_W    = 3 + 2*REG_ADDR_W,
    localparam int NUM_REGS   = 1 << REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    input  logic [INSTR_W-1:0]    instruction,
    output logic                  instr_ready,
    output logic [NUM_REGS-1:0]   rin,
    output logic [NUM_REGS-1:0]   rout,
    output logic                  ext_load,
    output logic [REG_ADDR_W-1:0] ext_imm,
    output logic                  alu_a_in,
    output logic                  alu_g_in,
    output logic                  alu_g_out,
    output logic [1:0]            alu_mode,
    output logic                  done,
    output logic                  illegal,
    output logic [CNT_W-1:0]      retired
);

    state_e                state_q, state_d;
    logic [INSTR_W-1:0]    ir_q, ir_d;
    logic [2:0]            op_d;
    logic [REG_ADDR_W-1:0] rx_d, ry_d;
    logic                  accept;

    logic                  rin_en_d, rout_en_d, ext_load_d, a_in_d, g_in_d, g_out_d;
    logic                  done_d, illegal_d, ready_d;
    logic [REG_ADDR_W-1:0] rin_addr_d, rout_addr_d, ext_imm_d;
    logic [1:0]            mode_d;

    logic                  rin_en_q, rout_en_q, ext_load_q, a_in_q, g_in_q, g_out_q;
    logic                  done_q, illegal_q, ready_q;
    logic [REG_ADDR_W-1:0] rin_addr_q, rout_addr_q, ext_imm_q;
    logic [1:0]            mode_q;
    logic [CNT_W-1:0]      retired_q;

    // ready_q is high exactly in IDLE and in the final step of an op.
    assign accept = instr_valid & ready_q;

    always_comb begin
        // NOTE: every always_comb target is given a default first so no path infers a latch.
        state_d = state_q;
        ir_d    = ir_q;
        if (ready_q) begin
            state_d = accept ? S_T1 : S_IDLE;
            if (accept) ir_d = instruction;
        end else if (state_q == S_T1) begin
            state_d = S_T2;
        end else begin
            state_d = S_T3;
        end
    end

    assign op_d = ir_d[INSTR_W-1 -: 3];
    assign rx_d = ir_d[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign ry_d = ir_d[REG_ADDR_W-1:0];

    // Outputs are decoded from the next state so they can be registered.
    always_comb begin
        rin_en_d    = 1'b0;
        rout_en_d   = 1'b0;
        ext_load_d  = 1'b0;
        a_in_d      = 1'b0;
        g_in_d      = 1'b0;
        g_out_d     = 1'b0;
        done_d      = 1'b0;
        illegal_d   = 1'b0;
        ready_d     = 1'b0;
        rin_addr_d  = rx_d;
        rout_addr_d = rx_d;
        ext_imm_d   = '0;
        mode_d      = MODE_ADD;
        case (state_d)
            S_IDLE: ready_d = 1'b1;
            S_T1: begin
                if (op_d == OP_LOAD) begin
                    rin_en_d   = 1'b1;
                    ext_load_d = 1'b1;
                    ext_imm_d  = ry_d;
                    done_d     = 1'b1;
                    ready_d    = 1'b1;
                end else if (op_d == OP_MOV) begin
                    rout_en_d   = 1'b1;
                    rout_addr_d = ry_d;
                    rin_en_d    = 1'b1;
                    done_d      = 1'b1;
                    ready_d     = 1'b1;
                end else if (is_alu_op(op_d)) begin
                    rout_en_d = 1'b1;
                    a_in_d    = 1'b1;
                end else begin
                    illegal_d = 1'b1;
                    ready_d   = 1'b1;
                end
            end
            S_T2: begin
                rout_en_d   = 1'b1;
                rout_addr_d = ry_d;
                g_in_d      = 1'b1;
                mode_d      = alu_mode_of(op_d);
            end
            S_T3: begin
                g_out_d  = 1'b1;
                rin_en_d = 1'b1;
                mode_d   = alu_mode_of(op_d);
                done_d   = 1'b1;
                ready_d  = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ir_q        <= '0;
            rin_en_q    <= 1'b0;
            rout_en_q   <= 1'b0;
            ext_load_q  <= 1'b0;
            a_in_q      <= 1'b0;
            g_in_q      <= 1'b0;
            g_out_q     <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            ready_q     <= 1'b1;
            rin_addr_q  <= '0;
            rout_addr_q <= '0;
            ext_imm_q   <= '0;
            mode_q      <= MODE_ADD;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            rin_en_q    <= rin_en_d;
            rout_en_q   <= rout_en_d;
            ext_load_q  <= ext_load_d;
            a_in_q      <= a_in_d;
            g_in_q      <= g_in_d;
            g_out_q     <= g_out_d;
            done_q      <= done_d;
            illegal_q   <= illegal_d;
            ready_q     <= ready_d;
            rin_addr_q  <= rin_addr_d;
            rout_addr_q <= rout_addr_d;
            ext_imm_q   <= ext_imm_d;
            mode_q      <= mode_d;
            if (done_d) retired_q <= retired_q + CNT_W'(1);
        end
    end

    ctrl_onehot_dec #(.ADDR_W(REG_ADDR_W)) u_rin_dec (
        .addr_i   (rin_addr_q),
        .en_i     (rin_en_q),
        .onehot_o (rin)
    );

    ctrl_onehot_dec #(.ADDR_W(REG_ADDR_W)) u_rout_dec (
        .addr_i   (rout_addr_q),
        .en_i     (rout_en_q),
        .onehot_o (rout)
    );

    assign instr_ready = ready_q;
    assign ext_load    = ext_load_q;
    assign ext_imm     = ext_imm_q;
    assign alu_a_in    = a_in_q;
    assign alu_g_in    = g_in_q;
    assign alu_g_out   = g_out_q;
    assign alu_mode    = mode_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_seq_control_unit.sv
// Scoreboard bench for seq_control_unit: a per-instruction step-list model feeds an expected queue
// that a monitor drains every cycle. Small retired counter so wrap-around is exercised.
module tb_seq_control_unit;

    localparam int AW = 4;
    localparam int CW = 4;
`ifdef CTRL_LOGIC_OPS_EN
    localparam bit LOGIC_EN = 1'b1;
`else
    localparam bit LOGIC_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] rin;
        logic [15:0] rout;
        logic        ext_load;
        logic [3:0]  ext_imm;
        logic        a_in;
        logic        g_in;
        logic        g_out;
        logic [1:0]  mode;
        logic        done;
        logic        illegal;
        logic        ready;
        logic [3:0]  retired;
    } rec_t;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [10:0] instruction;
    logic        instr_ready;
    logic [15:0] rin, rout;
    logic        ext_load;
    logic [3:0]  ext_imm;
    logic        alu_a_in, alu_g_in, alu_g_out;
    logic [1:0]  alu_mode;
    logic        done, illegal;
    logic [3:0]  retired;

    rec_t        exp_q[$];
    rec_t        seq[$];
    rec_t        cur;
    logic [3:0]  retired_m;
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cycle  = 0;

    seq_control_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .instr_ready (instr_ready),
        .rin         (rin),
        .rout        (rout),
        .ext_load    (ext_load),
        .ext_imm     (ext_imm),
        .alu_a_in    (alu_a_in),
        .alu_g_in    (alu_g_in),
        .alu_g_out   (alu_g_out),
        .alu_mode    (alu_mode),
        .done        (done),
        .illegal     (illegal),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    function automatic rec_t blank();
        rec_t r = '{default: '0};
        return r;
    endfunction

    function automatic rec_t idle_rec();
        rec_t r = blank();
        r.ready = 1'b1;
        return r;
    endfunction

    function automatic bit is_alu(input logic [2:0] op);
        return (op == 3'd2) || (op == 3'd3) || (LOGIC_EN && (op == 3'd4 || op == 3'd5));
    endfunction

    // Expand one accepted instruction into the list of cycles it should present.
    task automatic expand(input logic [10:0] ins);
        logic [2:0] op;
        logic [3:0] rx, ry;
        rec_t       r;
        op = ins[10:8];
        rx = ins[7:4];
        ry = ins[3:0];
        if (op == 3'd0) begin
            r = blank();
            r.rin = 16'b1 << rx; r.ext_load = 1'b1; r.ext_imm = ry; r.done = 1'b1; r.ready = 1'b1;
            seq.push_back(r);
        end else if (op == 3'd1) begin
            r = blank();
            r.rout = 16'b1 << ry; r.rin = 16'b1 << rx; r.done = 1'b1; r.ready = 1'b1;
            seq.push_back(r);
        end else if (is_alu(op)) begin
            r = blank();
            r.rout = 16'b1 << rx; r.a_in = 1'b1;
            seq.push_back(r);
            r = blank();
            r.rout = 16'b1 << ry; r.g_in = 1'b1; r.mode = 2'(op - 3'd2);
            seq.push_back(r);
            r = blank();
            r.g_out = 1'b1; r.rin = 16'b1 << rx; r.mode = 2'(op - 3'd2); r.done = 1'b1; r.ready = 1'b1;
            seq.push_back(r);
        end else begin
            r = blank();
            r.illegal = 1'b1; r.ready = 1'b1;
            seq.push_back(r);
        end
    endtask

    // Drive one cycle of stimulus, predict the cycle after the coming edge, then wait it out.
    task automatic step(input logic rst, input logic v, input logic [10:0] ins);
        rec_t nxt;
        reset       = rst;
        instr_valid = v;
        instruction = ins;
        if (rst) begin
            seq.delete();
            retired_m = '0;
            nxt = idle_rec();
        end else begin
            if (v && cur.ready) begin
                seq.delete();
                expand(ins);
            end
            nxt = (seq.size() != 0) ? seq.pop_front() : idle_rec();
            if (nxt.done) retired_m++;
        end
        nxt.retired = retired_m;
        cur = nxt;
        exp_q.push_back(nxt);
        @(negedge clk);
    endtask

    function automatic logic [10:0] mk(input logic [2:0] op, input logic [3:0] rx, input logic [3:0] ry);
        return {op, rx, ry};
    endfunction

    initial begin : monitor
        rec_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL scoreboard_empty cycle %0d: got no expectation, required one", cycle);
            end else begin
                e = exp_q.pop_front();
                check("instr_ready", 32'(instr_ready), 32'(e.ready));
                check("rin",         32'(rin),         32'(e.rin));
                check("rout",        32'(rout),        32'(e.rout));
                check("ext_load",    32'(ext_load),    32'(e.ext_load));
                check("ext_imm",     32'(ext_imm),     32'(e.ext_imm));
                check("alu_a_in",    32'(alu_a_in),    32'(e.a_in));
                check("alu_g_in",    32'(alu_g_in),    32'(e.g_in));
                check("alu_g_out",   32'(alu_g_out),   32'(e.g_out));
                check("alu_mode",    32'(alu_mode),    32'(e.mode));
                check("done",        32'(done),        32'(e.done));
                check("illegal",     32'(illegal),     32'(e.illegal));
                check("retired",     32'(retired),     32'(e.retired));
            end
        end
    end

    initial begin : stimulus
        cur = idle_rec();
        retired_m = '0;

        step(1, 0, '0);
        step(0, 0, '0);
        step(0, 1, mk(3'd0, 4'd1, 4'd6));
        step(0, 0, '0);
        step(0, 1, mk(3'd1, 4'd1, 4'd2));
        step(0, 1, mk(3'd1, 4'd5, 4'd6));
        step(0, 0, '0);
        step(0, 1, mk(3'd2, 4'd3, 4'd4));
        step(0, 1, mk(3'd0, 4'd9, 4'd9));
        step(0, 1, mk(3'd1, 4'd8, 4'd7));
        step(0, 0, '0);
        step(0, 1, mk(3'd6, 4'd2, 4'd3));
        step(0, 1, mk(3'd7, 4'd0, 4'd0));
        step(0, 1, mk(3'd4, 4'd2, 4'd3));
        step(0, 0, '0);
        step(0, 0, '0);
        step(0, 1, mk(3'd5, 4'd15, 4'd0));
        step(0, 0, '0);
        step(0, 0, '0);
        step(0, 1, mk(3'd3, 4'd7, 4'd2));
        step(0, 0, '0);
        step(1, 0, '0);
        step(0, 0, '0);
        step(0, 1, mk(3'd1, 4'd3, 4'd3));
        step(0, 1, mk(3'd2, 4'd9, 4'd9));
        step(0, 0, '0);
        step(0, 0, '0);
        step(0, 0, '0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 7),
                 11'($urandom));
        end
        step(0, 0, '0);
        step(0, 0, '0);
        step(0, 0, '0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
